multicycle_ctrl: RTL and testbench

Multicycle sequencer for the 8-bit-data / 16-bit-instruction datapath. It runs a Moore FSM that fetches each instruction over a ready/valid memory handshake, decodes the opcode and steps the datapath through execute, memory and writeback. It drives the datapath select lines (`memtoreg`, `pcsrc`, `alusrc`, `regdst`, `regwrite`, `jump`, `alucontrol`) plus PC/IR write strobes. It sits between the datapath, the instruction memory port and the data memory port.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/multicycle_ctrl_if.sv | 27 ++
 rtl/multicycle_ctrl_aludec.sv | 34 +++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle controller:
// opcodes, FSM states, ALU operation and funct codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_LW    = 4'd1,
        OP_SW    = 4'd2,
        OP_BEQ   = 4'd3,
        OP_ADDI  = 4'd4,
        OP_J     = 4'd5,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_SLT = 3'd4;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory request/ready handshakes.
// The controller is the master; the memory side is the slave.
interface multicycle_ctrl_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// Opcode/funct to ALU operation decode.
// Flags opcodes and R-type functs the datapath cannot run.
module aludec
    import ctrl_pkg::*;
(
    input  logic [3:0] op,
    input  logic [2:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    // Pure table lookup; J and HALT never use the ALU.
    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: illegal    = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: alucontrol = ALU_ADD;
            OP_BEQ:                alucontrol = ALU_SUB;
            OP_J, OP_HALT:         alucontrol = ALU_ADD;
            default:               illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: fetch, decode, execute,
// memory and writeback with bounded memory waits.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              zero,
    multicycle_ctrl_if.master mem,
    output logic              irwrite,
    output logic              pcwrite,
    output logic              memtoreg,
    output logic              pcsrc,
    output logic              alusrc,
    output logic              regdst,
    output logic              regwrite,
    output logic              jump,
    output logic [2:0]        alucontrol,
    output logic              halted,
    output logic              illegal
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ill_q, set_ill;
    logic          imem_req_c, dmem_req_c, dmem_we_c;
    logic [3:0]    op;
    logic [2:0]    dec_alu;
    logic          dec_bad;
    logic          is_r, is_lw, is_sw, is_beq, is_j, is_halt;
    logic          unused_instr;

    assign op           = instr[15:12];
    assign unused_instr = ^instr[11:3];

    assign is_r    = (op == OP_RTYPE);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign is_halt = (op == OP_HALT);

    aludec u_aludec (
        .op         (op),
        .funct      (instr[2:0]),
        .alucontrol (dec_alu),
        .illegal    (dec_bad)
    );

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign halted       = (state == S_HALT);
    assign illegal      = ill_q;

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ill_q <= ill_q | set_ill;
        end
    end

    // Next state plus Moore outputs; only irwrite and
    // the store's pcwrite look at a ready input.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        set_ill    = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        jump       = 1'b0;
        alucontrol = 3'b000;
        unique case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                imem_req_c = 1'b1;
                irwrite    = mem.imem_ready;
                if (mem.imem_ready) begin
                    state_n = S_DECODE;
                end else if (cnt == TO) begin
                    state_n = S_HALT;
                    set_ill = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_n = S_HALT;
                end else if (dec_bad) begin
                    state_n = S_HALT;
                    set_ill = 1'b1;
                end else if (is_j) begin
                    jump    = 1'b1;
                    pcwrite = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                alucontrol = dec_alu;
                alusrc     = is_lw | is_sw | (op == OP_ADDI);
                if (is_beq) begin
                    pcsrc   = zero;
                    pcwrite = 1'b1;
                    state_n = S_FETCH;
                end else if (is_lw | is_sw) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_sw;
                if (mem.dmem_ready) begin
                    pcwrite = is_sw;
                    state_n = is_sw ? S_FETCH : S_WB;
                end else if (cnt == TO) begin
                    state_n = S_HALT;
                    set_ill = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                regdst   = is_r;
                memtoreg = is_lw;
                state_n  = S_FETCH;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
        if (state_n != state &&
            (state_n == S_FETCH || state_n == S_MEM)) begin
            cnt_n = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle
// plans built from the instruction's semantics.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    localparam int B_IMEM = 15;
    localparam int B_DMEM = 14;
    localparam int B_WE   = 13;
    localparam int B_IRW  = 12;
    localparam int B_PCW  = 11;
    localparam int B_M2R  = 10;
    localparam int B_PCS  = 9;
    localparam int B_ALUS = 8;
    localparam int B_RDST = 7;
    localparam int B_RW   = 6;
    localparam int B_J    = 5;
    localparam int B_HALT = 1;
    localparam int B_ILL  = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        zero = 1'b0;
    logic        irwrite, pcwrite, memtoreg, pcsrc, alusrc;
    logic        regdst, regwrite, jump, halted, illegal;
    logic [2:0]  alucontrol;
    logic [15:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] q_e[$];
    logic [15:0] q_in[$];
    logic        q_ir[$];
    logic        q_dr[$];
    logic        q_z[$];
    string       q_tag[$];
    bit          m_ill;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .mem        (mif),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .memtoreg   (memtoreg),
        .pcsrc      (pcsrc),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .jump       (jump),
        .alucontrol (alucontrol),
        .halted     (halted),
        .illegal    (illegal)
    );

    assign obs = {mif.imem_req, mif.dmem_req, mif.dmem_we,
                  irwrite, pcwrite, memtoreg, pcsrc, alusrc,
                  regdst, regwrite, jump, alucontrol,
                  halted, illegal};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] op,
                                          input logic [2:0] f);
        if (op == 4'd3) return 3'b110;
        if (op != 4'd0) return 3'b010;
        case (f)
            3'd0:    return 3'b010;
            3'd1:    return 3'b110;
            3'd2:    return 3'b000;
            3'd3:    return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic chk(input logic [15:0] expv, input string tag);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] e, input logic [15:0] in,
                        input logic ir, input logic dr,
                        input logic z, input string tag);
        q_e.push_back(e);
        q_in.push_back(in);
        q_ir.push_back(ir);
        q_dr.push_back(dr);
        q_z.push_back(z);
        q_tag.push_back(tag);
    endtask

    task automatic push_halt(input logic z);
        logic [15:0] e;
        e = '0;
        e[B_HALT] = 1'b1;
        e[B_ILL]  = m_ill;
        for (int i = 0; i < 3; i++)
            push(e, 16'($urandom), rb(), rb(), z, "halt");
    endtask

    // Expected per-cycle outputs of one instruction; wi/wd are
    // not-ready cycles before the fetch/data ready arrives.
    task automatic plan(input logic [15:0] ins, input logic z,
                        input int wi, input int wd);
        logic [15:0] e;
        logic [3:0]  op;
        logic [2:0]  f;
        bit          legal;
        op = ins[15:12];
        f  = ins[2:0];
        for (int i = 0; i < wi && i <= TIMEOUT; i++) begin
            e = '0; e[B_IMEM] = 1'b1;
            push(e, 16'($urandom), 1'b0, rb(), z, "fetch_wait");
        end
        if (wi > TIMEOUT) begin
            m_ill = 1'b1;
            push_halt(z);
            return;
        end
        e = '0; e[B_IMEM] = 1'b1; e[B_IRW] = 1'b1;
        push(e, 16'($urandom), 1'b1, rb(), z, "fetch");
        legal = (op <= 4'd5 || op == 4'd15) &&
                !(op == 4'd0 && f > 3'd4);
        e = '0;
        if (op == 4'd15 || !legal) begin
            push(e, ins, rb(), rb(), z, "decode");
            if (!legal) m_ill = 1'b1;
            push_halt(z);
            return;
        end
        if (op == 4'd5) begin
            e[B_J] = 1'b1; e[B_PCW] = 1'b1;
            push(e, ins, rb(), rb(), z, "decode_j");
            return;
        end
        push(e, ins, rb(), rb(), z, "decode");
        e = '0;
        e[4:2] = alu_of(op, f);
        e[B_ALUS] = (op == 4'd1 || op == 4'd2 || op == 4'd4);
        if (op == 4'd3) begin
            e[B_PCS] = z; e[B_PCW] = 1'b1;
            push(e, ins, rb(), rb(), z, "exec_beq");
            return;
        end
        push(e, ins, rb(), rb(), z, "exec");
        if (op == 4'd1 || op == 4'd2) begin
            e = '0; e[B_DMEM] = 1'b1; e[B_WE] = (op == 4'd2);
            for (int i = 0; i < wd && i <= TIMEOUT; i++)
                push(e, ins, rb(), 1'b0, z, "mem_wait");
            if (wd > TIMEOUT) begin
                m_ill = 1'b1;
                push_halt(z);
                return;
            end
            e[B_PCW] = (op == 4'd2);
            push(e, ins, rb(), 1'b1, z, "mem");
            if (op == 4'd2) return;
        end
        e = '0; e[B_RW] = 1'b1; e[B_PCW] = 1'b1;
        e[B_RDST] = (op == 4'd0);
        e[B_M2R]  = (op == 4'd1);
        push(e, ins, rb(), rb(), z, "wb");
    endtask

    // Replays queued cycles; entered just after a rising edge.
    task automatic run(input string name, input int limit);
        logic [15:0] e;
        string       t;
        int          k;
        k = 0;
        while (q_e.size() > 0 && (limit < 0 || k < limit)) begin
            e = q_e.pop_front();
            t = q_tag.pop_front();
            #1;
            instr          = q_in.pop_front();
            mif.imem_ready = q_ir.pop_front();
            mif.dmem_ready = q_dr.pop_front();
            zero           = q_z.pop_front();
            #1;
            chk(e, $sformatf("%s:%s#%0d", name, t, k));
            @(posedge clk);
            k++;
        end
    endtask

    task automatic do_reset(input string name);
        #1 reset = 1'b0;
        #1 chk('0, {name, ":async_reset"});
        @(posedge clk);
        #2 chk('0, {name, ":in_reset"});
        @(posedge clk);
        #1 reset = 1'b1;
        mif.imem_ready = 1'b1;
        #1 chk('0, {name, ":idle"});
        @(posedge clk);
        q_e.delete(); q_in.delete(); q_ir.delete();
        q_dr.delete(); q_z.delete(); q_tag.delete();
        m_ill = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        m_ill = 1'b0;
        mif.imem_ready = 1'b1;
        mif.dmem_ready = 1'b1;
        @(posedge clk);
        #2 chk('0, "reset_state");
        @(posedge clk);
        do_reset("start");

        plan(16'h0001, 1'b0, 0, 0);
        plan(16'h0001, 1'b0, 0, 0);
        run("rsub", -1);
        plan(16'h1234, 1'b0, 0, 3);
        run("lw_wait3", -1);
        plan(16'h3abc, 1'b1, 0, 0);
        plan(16'h3abc, 1'b0, 0, 0);
        run("beq", -1);
        plan(16'h5042, 1'b0, 0, 0);
        run("j", -1);
        plan(16'h2345, 1'b1, 1, 2);
        plan(16'h4111, 1'b0, 2, 0);
        plan(16'h0ff2, 1'b0, 0, 0);
        plan(16'h0ab3, 1'b1, 1, 0);
        plan(16'h0004, 1'b0, 0, 0);
        run("mix", -1);
        plan(16'h0000, 1'b0, TIMEOUT, 0);
        run("fetch_edge", -1);
        plan(16'h1000, 1'b0, 0, TIMEOUT);
        plan(16'h2000, 1'b0, 0, TIMEOUT);
        run("mem_edge", -1);

        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom_range(0, 5));
            ins = {op, 12'($urandom)};
            if (op == 4'd0) ins[2:0] = 3'($urandom_range(0, 4));
            plan(ins, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
            run($sformatf("rnd%0d_%h", n, ins), -1);
        end

        plan(16'h7123, 1'b0, 0, 0);
        run("bad_op", -1);
        do_reset("bad_op");
        plan(16'h0006, 1'b0, 0, 0);
        run("bad_funct", -1);
        do_reset("bad_funct");
        plan(16'hf000, 1'b0, 0, 0);
        run("halt_op", -1);
        do_reset("halt_op");
        plan(16'h0001, 1'b0, TIMEOUT + 1, 0);
        run("imem_timeout", -1);
        do_reset("imem_timeout");
        plan(16'h1000, 1'b0, 0, TIMEOUT + 1);
        run("dmem_timeout", -1);
        do_reset("dmem_timeout");
        plan(16'h2000, 1'b0, 0, 5);
        run("mid_mem", 5);
        do_reset("mid_mem");
        plan(16'h0001, 1'b0, 0, 0);
        run("recover", -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
